// File: rtl/shift_ctrl_pkg.sv
// Purpose : shared types and constants for the shift channel arbiter.
// Contents: FSM state encoding, default requester/frame sizes and the
//           helper that sizes the bit counter.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;

  // Bit counter width; never below one bit so the vector stays legal.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin select. The search starts at ptr_i
//           and wraps modulo NUM_REQ; the first asserted request wins.
// Ports   : req_i        request vector
//           ptr_i        priority pointer (highest priority index)
//           grant_oh_o   one-hot winner (all zero when nothing requests)
//           grant_idx_o  winner index
//           valid_o      at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [IW-1:0]      grant_idx_o,
  output logic               valid_o
);

  always_comb begin
    int idx;
    idx         = 0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      // Only the first hit after the pointer is kept.
      if (!valid_o && req_i[idx]) begin
        valid_o         = 1'b1;
        grant_idx_o     = IW'(idx);
        grant_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_channel_arbiter.sv
// Purpose : shares one serial shift channel among NUM_REQ parallel
//           requesters. In IDLE the round-robin winner's word is loaded
//           into a right-shifting register and sent LSB first, one bit per
//           enabled clock, followed by a one-cycle GAP.
// Request contract: Req_In is a level sampled only in IDLE. Data_In of a
//           requesting lane must be stable until its grant; a request that
//           drops before being sampled is simply withdrawn. A request still
//           high when the FSM returns to IDLE competes again.
// Ports   : Clk_In, Reset_In (async active-low)
//           Req_In / Data_In       requester levels and packed lane data
//           Shift_En_In            advance enable during SHIFT
//           Grant_Out              one-cycle one-hot capture pulse
//           Owner_Out              current/last granted index
//           Serial_Data_Out        current bit, 0 outside SHIFT
//           Frame_Valid_Out        high in SHIFT
//           Busy_Out               high in SHIFT and GAP
//           Done_Out               one-cycle pulse in the GAP cycle
//           Dbg_State_Out          FSM state for observation
// All outputs come straight from registers.
module shift_channel_arbiter
  import shift_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          Clk_In,
  input  logic                          Reset_In,
  input  logic [NUM_REQ-1:0]            Req_In,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_In,
  input  logic                          Shift_En_In,
  output logic [NUM_REQ-1:0]            Grant_Out,
  output logic [$clog2(NUM_REQ)-1:0]    Owner_Out,
  output logic                          Serial_Data_Out,
  output logic                          Frame_Valid_Out,
  output logic                          Busy_Out,
  output logic                          Done_Out,
  output state_e                        Dbg_State_Out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    serial_q, serial_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [NUM_REQ-1:0]      win_oh;
  logic [IW-1:0]           win_idx;
  logic                    win_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req_i       (Req_In),
    .ptr_i       (ptr_q),
    .grant_oh_o  (win_oh),
    .grant_idx_o (win_idx),
    .valid_o     (win_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_SHIFT;
          shreg_d = Data_In[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          cnt_d   = '0;
          owner_d = win_idx;
          // Pointer moves past the winner so a persistent requester yields.
          ptr_d   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          grant_d = win_oh;
        end
      end
      ST_SHIFT: begin
        if (Shift_En_In) begin
          shreg_d = shreg_q >> 1;
          if (cnt_q == LAST_BIT) begin
            state_d = ST_GAP;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs are derived from next state so they line up with
    // the cycle they describe.
    serial_d = (state_d == ST_SHIFT) ? shreg_d[0] : 1'b0;
    valid_d  = (state_d == ST_SHIFT);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      serial_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      serial_q <= serial_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Grant_Out       = grant_q;
  assign Owner_Out       = owner_q;
  assign Serial_Data_Out = serial_q;
  assign Frame_Valid_Out = valid_q;
  assign Busy_Out        = busy_q;
  assign Done_Out        = done_q;
  assign Dbg_State_Out   = state_q;

endmodule

// File: tb/tb_shift_channel_arbiter.sv
module tb_shift_channel_arbiter;
  import shift_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] data;
  logic             en;
  logic [NR-1:0]    grant;
  logic [1:0]       owner;
  logic             serial;
  logic             valid;
  logic             busy;
  logic             done;
  state_e           state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  shift_channel_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .Clk_In          (clk),
    .Reset_In        (rst_n),
    .Req_In          (req),
    .Data_In         (data),
    .Shift_En_In     (en),
    .Grant_Out       (grant),
    .Owner_Out       (owner),
    .Serial_Data_Out (serial),
    .Frame_Valid_Out (valid),
    .Busy_Out        (busy),
    .Done_Out        (done),
    .Dbg_State_Out   (state)
  );

  // ---------------- scoreboard ----------------
  int         total;
  int         bad;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || state != ST_IDLE) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  logic [7:0] frame;
  int         exp_order[5];
  int         grants;
  int         last_c;
  int         vcnt;
  int         dcnt;
  int         done_c;
  bit         done_seen;
  bit         got;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    en    = 1'b1;
    exp_order = '{0, 1, 2, 3, 0};

    // ---- reset state ----
    @(negedge clk);
    check("rst_grant",  {28'd0, grant}, 32'd0);
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_valid",  {31'd0, valid}, 32'd0);
    check("rst_state",  {30'd0, state}, {30'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single frame A5 from lane 2 ----
    @(negedge clk);
    req = 4'b0100;
    data[2*DW +: DW] = 8'hA5;
    frame = 8'hA5;
    for (int b = 0; b < DW; b++) exp_q.push_back(frame[b]);
    @(negedge clk);
    check("t1_grant", {28'd0, grant}, 32'd4);
    check("t1_owner", {30'd0, owner}, 32'd2);
    req = 4'b0000;
    for (int i = 0; i < DW; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check("t1_grant_off", {28'd0, grant}, 32'd0);
      end
      check("t1_serial", {31'd0, serial}, {31'd0, exp_q.pop_front()});
      check("t1_valid",  {31'd0, valid},  32'd1);
      check("t1_nodone", {31'd0, done},   32'd0);
    end
    @(negedge clk);
    check("t1_gap_valid",  {31'd0, valid},  32'd0);
    check("t1_gap_done",   {31'd0, done},   32'd1);
    check("t1_gap_busy",   {31'd0, busy},   32'd1);
    check("t1_gap_serial", {31'd0, serial}, 32'd0);
    @(negedge clk);
    check("t1_idle_done", {31'd0, done}, 32'd0);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);

    // ---- all four requesting, pointer from 0 ----
    do_reset();
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req  = 4'b1111;
    grants = 0;
    last_c = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      check("t2_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
      if (grant != 0 && grants < 5) begin
        check("t2_order", {30'd0, owner}, exp_order[grants]);
        check("t2_grant", {28'd0, grant}, 32'd1 << exp_order[grants]);
        if (grants > 0) check("t2_spacing", c - last_c, 32'd10);
        last_c = c;
        grants++;
      end
    end
    check("t2_count", grants, 32'd5);
    req = 4'b0000;
    wait_idle("t2_idle");

    // ---- FF frame with a 3-cycle stall after bit 2 ----
    @(negedge clk);
    data = '0;
    data[0 +: DW] = 8'hFF;
    req = 4'b0001;
    vcnt = 0;
    dcnt = 0;
    done_c = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("t3_grant", {28'd0, grant}, 32'd1);
        req = 4'b0000;
      end
      if (c == 3) en = 1'b0;
      if (c == 6) en = 1'b1;
      if (c == 5) check("t3_hold_valid", {31'd0, valid}, 32'd1);
      if (valid) vcnt++;
      if (done) begin
        dcnt++;
        done_c = c;
      end
    end
    check("t3_valid_cycles", vcnt,   32'd11);
    check("t3_done_count",   dcnt,   32'd1);
    check("t3_done_cycle",   done_c, 32'd12);

    // ---- async reset at bit 4 of 3C ----
    @(negedge clk);
    data[0 +: DW] = 8'h3C;
    frame = 8'h3C;
    req = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) req = 4'b0000;
      check("t4_serial", {31'd0, serial}, {31'd0, frame[c-1]});
    end
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_grant",  {28'd0, grant},  32'd0);
    check("t4_rst_serial", {31'd0, serial}, 32'd0);
    check("t4_rst_valid",  {31'd0, valid},  32'd0);
    check("t4_rst_busy",   {31'd0, busy},   32'd0);
    check("t4_rst_done",   {31'd0, done},   32'd0);
    check("t4_rst_owner",  {30'd0, owner},  32'd0);
    done_seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("t4_no_done", {31'd0, done_seen}, 32'd0);
    // Lanes 0 and 3 both ask: a cleared pointer must pick 0.
    req = 4'b1001;
    @(negedge clk);
    check("t4_regrant", {28'd0, grant}, 32'd1);
    check("t4_owner",   {30'd0, owner}, 32'd0);
    req = 4'b0000;
    wait_idle("t4_idle");

    // ---- fairness: held req 1, late req 3 ----
    @(negedge clk);
    req = 4'b0010;
    got = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) check("t5_first", {28'd0, grant}, 32'd2);
      if (c == 3) req = 4'b1010;
      if (c > 1 && grant != 0) begin
        check("t5_next_grant", {28'd0, grant}, 32'd8);
        check("t5_next_owner", {30'd0, owner}, 32'd3);
        check("t5_next_cycle", c, 32'd11);
        got = 1'b1;
        break;
      end
    end
    check("t5_got_grant", {31'd0, got}, 32'd1);
    req = 4'b0000;
    wait_idle("t5_idle");

    // ---- request glitch between edges ----
    @(negedge clk);
    #1 req = 4'b1111;
    #2 req = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      check("t6_grant", {28'd0, grant}, 32'd0);
      check("t6_busy",  {31'd0, busy},  32'd0);
      check("t6_state", {30'd0, state}, {30'd0, ST_IDLE});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_channel_arbiter.md
# shift_channel_arbiter

Round-robin controller that shares one 8-bit serial shift channel among several parallel-data requesters. It grants one requester at a time, loads that requester's byte into an internal right-shifting register, and shifts it out LSB first, one bit per enabled clock. Completion is reported with a pulse. It sits between the parallel producers and the single serial link in the shift-register subsystem.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 8: bits per frame, 2..16.
- Clk_In  input  1  single clock; all state is updated on the rising edge.
- Reset_In  input  1  asynchronous, active-low reset.
- Req_In  input  NUM_REQ  per-requester request level.
- Data_In  input  NUM_REQ*DATA_WIDTH  requester i's data is in bits [i*DATA_WIDTH +: DATA_WIDTH].
- Shift_En_In  input  1  advance enable while shifting; low stalls the frame.
- Grant_Out  output  NUM_REQ  one-hot, one-cycle pulse when a requester's data has been captured.
- Owner_Out  output  $clog2(NUM_REQ)  index of the current or last granted requester.
- Serial_Data_Out  output  1  current bit; 0 when no frame is active.
- Frame_Valid_Out  output  1  high for every cycle in SHIFT.
- Busy_Out  output  1  high in SHIFT and GAP.
- Done_Out  output  1  one-cycle pulse after the last bit has been shifted.

## Operation
- All outputs are registered.
- **FSM states:** IDLE, SHIFT, GAP.
- **IDLE:**
  - If any Req_In bit is high at the edge, the round-robin winner is chosen.
  - The search starts at the priority pointer and wraps modulo NUM_REQ.
  - The winner's Data_In is captured into the shift register, and the bit counter is cleared.
  - Owner_Out takes the winner index, and the pointer takes winner+1 mod NUM_REQ.
  - Grant_Out[winner] is high in the next cycle only. The state moves to SHIFT.
- **SHIFT:**
  - Serial_Data_Out equals shift_reg[0].
  - On each edge with Shift_En_In=1, shift right (fill with 0) and increment the counter.
  - If the counter equals DATA_WIDTH-1 at that edge, go to GAP and pulse Done_Out in the GAP cycle.
  - With Shift_En_In=0, the register, counter and outputs hold.
- **GAP:**
  - One cycle. Serial_Data_Out=0, Frame_Valid_Out=0, Busy_Out=1. Then go to IDLE.
- **Requester contract:**
  - Data_In must be stable while Req_In is high and ungranted.
  - A Req_In dropped before grant is a withdrawal, with no side effect.
  - Req_In is ignored outside IDLE.
  - Req_In still high on return to IDLE counts as a new request.
- **Fairness:** a continuously requesting owner cannot win twice in a row while another requester is waiting.
- **Reset (Reset_In=0, any time, including mid-frame):**
  - State goes to IDLE; pointer, counter, shift register and Owner_Out go to 0.
  - Grant_Out, Serial_Data_Out, Frame_Valid_Out, Busy_Out and Done_Out go to 0.
  - An aborted frame never pulses Done_Out.
- Bit counter width is $clog2(DATA_WIDTH). Compare exactly against DATA_WIDTH-1, with no wrap beyond it.

## Timing
- Request to grant: Req_In high at edge N gives Grant_Out and Frame_Valid_Out high at cycle N+1, with bit 0 on Serial_Data_Out.
- Bit k is presented in the cycle after the k-th enabled shift edge.
- A receiver samples when Frame_Valid_Out && Shift_En_In.
- With Shift_En_In held high, a frame occupies DATA_WIDTH cycles of SHIFT.
- Done_Out appears 1 cycle after the last bit cycle.
- Minimum request-to-request spacing is DATA_WIDTH+2 cycles (SHIFT + GAP + IDLE). That is 10 cycles at the defaults.
- Simultaneous requests: exactly one grant per IDLE cycle, and never two Grant_Out bits at once.
- Shift_En_In low during the final bit: Done_Out is delayed until the enabled edge.

## Structure
- **Package shift_ctrl_pkg:**
  - State encoding IDLE=2'd0, SHIFT=2'd1, GAP=2'd2.
  - Default NUM_REQ and DATA_WIDTH constants.
  - Counter width function.
- **Sub-module rr_arbiter:**
  - Purely combinational round-robin priority select.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner, winner index, any-valid flag.
- The top level holds the FSM, the pointer register, the shift register, the counter and the output registers.

## Test plan
- After reset, Req_In=4'b0100 with Data_In lane 2=8'hA5 and Shift_En_In=1:
  - Grant_Out=4'b0100 for 1 cycle, Owner_Out=2.
  - Serial_Data_Out sequence 1,0,1,0,0,1,0,1 with Frame_Valid_Out high for 8 cycles.
  - Done_Out pulses 1 cycle later.
- Req_In=4'b1111 held:
  - Grants in order 0,1,2,3,0.
  - Consecutive grants are 10 cycles apart, and Grant_Out is never multi-hot.
- Frame 8'hFF with Shift_En_In low for 3 cycles after bit 2:
  - The bit holds, Frame_Valid_Out stays high, and the frame spans 11 cycles.
  - Done_Out pulses exactly once.
- Reset_In low at bit 4 of frame 8'h3C:
  - All outputs are 0 immediately (asynchronously), and Done_Out never asserts.
  - Next Req_In=4'b0001 grants requester 0 from pointer 0.
- Req_In=4'b0010 held continuously plus a new Req_In[3] during its frame:
  - The next grant goes to 3, not 1.
- Req_In pulsed high for 0 cycles across an edge (glitch between edges):
  - No grant, and the state stays IDLE.
